icache_dm: RTL

//  Direct-mapped, read-only instruction cache between RV32i_top imem port and wsync_mem imem.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_refill_fsm.sv | 106 ++++++++++
 rtl/icache_dm.sv | 110 +++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// Field widths derive from the line count and words per line; extract helpers return 32-bit values.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP, FILL} state_e;

  function automatic int ob_w(input int lw);
    return $clog2(lw);
  endfunction

  function automatic int ib_w(input int nl);
    return $clog2(nl);
  endfunction

  function automatic int tb_w(input int nl, input int lw);
    return 30 - ob_w(lw) - ib_w(nl);
  endfunction

  function automatic logic [31:0] off_of(input logic [31:0] a, input int lw);
    return (a >> 2) & 32'(lw - 1);
  endfunction

  function automatic logic [31:0] idx_of(input logic [31:0] a, input int nl, input int lw);
    return (a >> (2 + ob_w(lw))) & 32'(nl - 1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a, input int nl, input int lw);
    return a >> (2 + ob_w(lw) + ib_w(nl));
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: one memory handshake per word, with a one-cycle gap between requests
// so the memory's wait counter re-arms. Tracks flushes that land while a line is in flight.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int MEM_AW     = 10,
  localparam int OB        = ob_w(LINE_WORDS),
  localparam int LB        = 30 - OB
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              start_i,
  input  logic [LB-1:0]     line_i,
  input  logic              flush_i,
  input  logic              mem_valid_i,
  output logic [MEM_AW-1:0] mem_add_o,
  output logic              mem_re_o,
  output state_e            state_o,
  output logic [OB-1:0]     wcnt_o,
  output logic [LB-1:0]     line_o,
  output logic              wr_en_o,
  output logic              fill_o,
  output logic              flush_pend_o
);

  localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [OB-1:0]     wcnt_q, wcnt_d;
  logic [LB-1:0]     line_q, line_d;
  logic              flush_pend_q, flush_pend_d;
  logic              mem_re_q, mem_re_d;
  logic [MEM_AW-1:0] mem_add_q, mem_add_d;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_add_q    <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
      mem_re_q     <= mem_re_d;
      mem_add_q    <= mem_add_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    line_d       = line_q;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = REQ;
          wcnt_d       = '0;
          line_d       = line_i;
          flush_pend_d = 1'b0;
        end
      end
      REQ: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_valid_i) begin
          if (wcnt_q == LAST) begin
            state_d = FILL;
          end else begin
            wcnt_d  = wcnt_q + 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (flush_i) flush_pend_d = 1'b1;
        state_d = REQ;
      end
      FILL: begin
        if (flush_i) flush_pend_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Request lines are registered: they follow the state being entered.
    mem_re_d  = (state_d == REQ);
    mem_add_d = (state_d == REQ) ? MEM_AW'({line_d, wcnt_d}) : mem_add_q;
  end

  always_comb begin
    wr_en_o = (state_q == REQ) && mem_valid_i;
    fill_o  = (state_q == FILL);
  end

  assign mem_add_o    = mem_add_q;
  assign mem_re_o     = mem_re_q;
  assign state_o      = state_q;
  assign wcnt_o       = wcnt_q;
  assign line_o       = line_q;
  assign flush_pend_o = flush_pend_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: hits answer in the request cycle, misses
// refill the whole line through icache_refill_fsm, then the held request hits.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NLINES     = 16,
  parameter int LINE_WORDS = 4,
  parameter int MEM_AW     = 10
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [31:0]       core_add_i,
  input  logic              core_re_i,
  output logic [31:0]       core_data_o,
  output logic              core_valid_o,
  input  logic              flush_i,
  output logic [MEM_AW-1:0] mem_add_o,
  output logic              mem_re_o,
  input  logic [31:0]       mem_data_i,
  input  logic              mem_valid_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int OB = ob_w(LINE_WORDS);
  localparam int IB = ib_w(NLINES);
  localparam int TB = tb_w(NLINES, LINE_WORDS);
  localparam int LB = TB + IB;

  logic              valid_q [NLINES];
  logic [TB-1:0]     tag_q   [NLINES];
  logic [31:0]       data_q  [NLINES][LINE_WORDS];
  logic [31:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [OB-1:0]     off;
  logic [IB-1:0]     idx;
  logic [TB-1:0]     tag;
  logic              hit, miss;

  state_e            state;
  logic [OB-1:0]     wcnt;
  logic [LB-1:0]     line;
  logic              wr_en, fill, flush_pend;
  logic [IB-1:0]     fill_idx;
  logic [TB-1:0]     fill_tag;

  assign off  = OB'(off_of(core_add_i, LINE_WORDS));
  assign idx  = IB'(idx_of(core_add_i, NLINES, LINE_WORDS));
  assign tag  = TB'(tag_of(core_add_i, NLINES, LINE_WORDS));

  assign hit  = (state == IDLE) && core_re_i && valid_q[idx] && (tag_q[idx] == tag);
  assign miss = (state == IDLE) && core_re_i && !hit;

  assign core_valid_o = hit;
  assign core_data_o  = hit ? data_q[idx][off] : 32'd0;

  assign fill_idx = line[IB-1:0];
  assign fill_tag = line[LB-1:IB];

  icache_refill_fsm #(
    .LINE_WORDS (LINE_WORDS),
    .MEM_AW     (MEM_AW)
  ) u_refill (
    .clk_i        (clk_i),
    .resetn_i     (resetn_i),
    .start_i      (miss),
    .line_i       ({tag, idx}),
    .flush_i      (flush_i),
    .mem_valid_i  (mem_valid_i),
    .mem_add_o    (mem_add_o),
    .mem_re_o     (mem_re_o),
    .state_o      (state),
    .wcnt_o       (wcnt),
    .line_o       (line),
    .wr_en_o      (wr_en),
    .fill_o       (fill),
    .flush_pend_o (flush_pend)
  );

  // A flush in the FILL cycle wins over the install, so the line stays invalid.
  for (genvar gi = 0; gi < NLINES; gi++) begin : g_valid
    always_ff @(posedge clk_i) begin
      if (!resetn_i)                          valid_q[gi] <= 1'b0;
      else if (flush_i)                       valid_q[gi] <= 1'b0;
      else if (fill && fill_idx == IB'(gi))   valid_q[gi] <= ~flush_pend;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill)  tag_q[fill_idx]        <= fill_tag;
    if (wr_en) data_q[fill_idx][wcnt] <= mem_data_i;
  end

  assign hit_cnt_d  = hit_cnt_q + 32'(hit);
  assign miss_cnt_d = miss_cnt_q + 32'(miss);

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
